// File: rtl/trap_controller_if.sv
// Trap controller bus: core-control and CSR-file signals around the trap sequencer.
//   slave  : seen by trap_controller (core/CSR values in, trap strobes and redirect out)
//   master : seen by the core/CSR side driving the controller
interface trap_controller_if;
  // interrupt sources
  logic        irq_ext;
  logic        irq_soft;
  logic        irq_timer;
  // execute-stage instruction info
  logic        instr_valid;
  logic [31:0] pc;
  logic        exc_ecall;
  logic        exc_illegal;
  logic [31:0] exc_tval;
  logic        mret;
  // CSR file state
  logic        mstatus_mie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc_in;
  // controller results
  logic        stall;
  logic        trap_we;
  logic [31:0] trap_mepc;
  logic [31:0] trap_mcause;
  logic [31:0] trap_mtval;
  logic        mret_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mip;

  modport slave (
    input  irq_ext, irq_soft, irq_timer,
    input  instr_valid, pc, exc_ecall, exc_illegal, exc_tval, mret,
    input  mstatus_mie, mie, mtvec, mepc_in,
    output stall, trap_we, trap_mepc, trap_mcause, trap_mtval,
    output mret_we, redirect_valid, redirect_pc, mip
  );

  modport master (
    output irq_ext, irq_soft, irq_timer,
    output instr_valid, pc, exc_ecall, exc_illegal, exc_tval, mret,
    output mstatus_mie, mie, mtvec, mepc_in,
    input  stall, trap_we, trap_mepc, trap_mcause, trap_mtval,
    input  mret_we, redirect_valid, redirect_pc, mip
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer. Picks the highest-priority exception/interrupt for the
// instruction in execute, strobes mepc/mcause/mtval/mstatus into the CSR file, then
// redirects fetch to the handler; MRET strobes the mstatus restore and redirects to mepc.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  trap_controller_if.slave: irq/instruction/CSR inputs; stall, trap_*, mret_we,
//        redirect_*, mip outputs (all registered)
module trap_controller #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          VECTORED_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  trap_controller_if.slave bus
);

  localparam int unsigned XLEN        = 32;
  localparam int unsigned IRQ_EXT_BIT = 11;
  localparam int unsigned IRQ_TMR_BIT = 7;
  localparam int unsigned IRQ_SW_BIT  = 3;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [XLEN-1:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_SOFT    = 32'h8000_0003;
  localparam logic [XLEN-1:0] CAUSE_TIMER   = 32'h8000_0007;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    VECTOR = 2'd2,
    RETURN = 2'd3
  } state_t;

  state_t state_q, state_d;

  // captured cause: interrupt flag and low code bits are all the vector target needs
  logic       cause_irq_q, cause_irq_d;
  logic [4:0] cause_code_q, cause_code_d;

  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [XLEN-1:0]        pending_c;
  logic [XLEN-1:0]        enabled_c;
  logic                   irq_take_c;
  logic [XLEN-1:0]        vector_pc_c;
  logic [XLEN-1:0]        cause_c;
  logic [XLEN-1:0]        tval_c;

  logic            stall_d, trap_we_d, mret_we_d, redirect_valid_d;
  logic [XLEN-1:0] trap_mepc_d, trap_mcause_d, trap_mtval_d, redirect_pc_d;

  // irq_ext synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync_q <= '0;
    end else begin
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], bus.irq_ext};
    end
  end

  // pending vector; soft/timer are already clock-synchronous
  always_comb begin
    pending_c              = '0;
    pending_c[IRQ_EXT_BIT] = ext_sync_q[SYNC_STAGES-1];
    pending_c[IRQ_TMR_BIT] = bus.irq_timer;
    pending_c[IRQ_SW_BIT]  = bus.irq_soft;
  end

  assign enabled_c  = pending_c & bus.mie;
  assign irq_take_c = bus.mstatus_mie && (enabled_c != '0);

  // handler target; vectored mode only offsets interrupts
  always_comb begin
    vector_pc_c = {bus.mtvec[XLEN-1:2], 2'b00};
    if (VECTORED_EN && (bus.mtvec[1:0] == 2'b01) && cause_irq_q) begin
      vector_pc_c = vector_pc_c + XLEN'({cause_code_q, 2'b00});
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cause_irq_q  <= 1'b0;
      cause_code_q <= '0;
    end else begin
      state_q      <= state_d;
      cause_irq_q  <= cause_irq_d;
      cause_code_q <= cause_code_d;
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_d          = state_q;
    cause_irq_d      = cause_irq_q;
    cause_code_d     = cause_code_q;
    cause_c          = '0;
    tval_c           = '0;
    trap_we_d        = 1'b0;
    trap_mepc_d      = '0;
    trap_mcause_d    = '0;
    trap_mtval_d     = '0;
    mret_we_d        = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          if (bus.exc_illegal) begin
            cause_c = CAUSE_ILLEGAL;
            tval_c  = bus.exc_tval;
            state_d = ENTER;
          end else if (bus.exc_ecall) begin
            cause_c = CAUSE_ECALL;
            state_d = ENTER;
          end else if (irq_take_c) begin
            if (enabled_c[IRQ_EXT_BIT]) begin
              cause_c = CAUSE_EXT;
            end else if (enabled_c[IRQ_SW_BIT]) begin
              cause_c = CAUSE_SOFT;
            end else begin
              cause_c = CAUSE_TIMER;
            end
            state_d = ENTER;
          end else if (bus.mret) begin
            state_d = RETURN;
          end
        end

        if (state_d == ENTER) begin
          cause_irq_d   = cause_c[XLEN-1];
          cause_code_d  = cause_c[4:0];
          trap_we_d     = 1'b1;
          trap_mepc_d   = bus.pc;
          trap_mcause_d = cause_c;
          trap_mtval_d  = tval_c;
        end else if (state_d == RETURN) begin
          mret_we_d        = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = bus.mepc_in;
        end
      end

      ENTER: begin
        state_d          = VECTOR;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = vector_pc_c;
      end

      VECTOR: state_d = IDLE;

      RETURN: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  // registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stall          <= 1'b0;
      bus.trap_we        <= 1'b0;
      bus.trap_mepc      <= '0;
      bus.trap_mcause    <= '0;
      bus.trap_mtval     <= '0;
      bus.mret_we        <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.mip            <= '0;
    end else begin
      bus.stall          <= stall_d;
      bus.trap_we        <= trap_we_d;
      bus.trap_mepc      <= trap_mepc_d;
      bus.trap_mcause    <= trap_mcause_d;
      bus.trap_mtval     <= trap_mtval_d;
      bus.mret_we        <= mret_we_d;
      bus.redirect_valid <= redirect_valid_d;
      bus.redirect_pc    <= redirect_pc_d;
      bus.mip            <= pending_c;
    end
  end

endmodule
